// File: rtl/sram_1rw_256x32_ctrl.sv
// Request-side controller for the single-port 256x32 SRAM macro: drives the active-low
// pin protocol and returns read data through a credit-protected response FIFO.

module sram_1rw_256x32_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    output logic [DATA_WIDTH-1:0] sram_i,
    input  logic [DATA_WIDTH-1:0] sram_o
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(RSP_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(RSP_DEPTH - 1);

    logic                  rd_pending_r;
    logic [CW-1:0]         count_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [DATA_WIDTH-1:0] fifo_mem_r [RSP_DEPTH];

    logic        fire_s;
    logic        push_s;
    logic        pop_s;
    logic [CW:0] occ_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Occupancy counts the read already launched into the macro, so a read is only
    // accepted when a FIFO slot is guaranteed for its data regardless of rsp_ready.
    assign occ_s  = {1'b0, count_r} + {{CW{1'b0}}, rd_pending_r};
    assign fire_s = req_valid & req_ready;
    assign push_s = rd_pending_r;
    assign pop_s  = rsp_valid & rsp_ready;

    // Request acceptance: writes always fit, reads need a credit; nothing while in reset.
    always_comb begin
        req_ready = 1'b0;
        if (!rst_n) begin
            req_ready = 1'b0;
        end else if (req_we) begin
            req_ready = 1'b1;
        end else begin
            req_ready = (occ_s < DEPTH_OCC);
        end
    end

    assign sram_csb  = ~fire_s;
    assign sram_web  = ~req_we;
    assign sram_a    = req_addr;
    assign sram_i    = req_wdata;
    assign sram_oeb  = ~rd_pending_r;
    assign rsp_valid = (count_r != {CW{1'b0}});
    assign rsp_rdata = fifo_mem_r[rd_ptr_r];

    // Capture-cycle flag: high in the cycle after a read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending_r <= 1'b0;
        end else begin
            rd_pending_r <= fire_s & ~req_we;
        end
    end

    // Response FIFO pointers, occupancy and storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= sram_o;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    sram_1rw_256x32_ctrl_chk #(
        .CW        (CW),
        .DEPTH_CNT (DEPTH_CNT)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .count   (count_r)
    );

endmodule

// Simulation checker: the credit scheme must make a push into a full FIFO impossible.
module sram_1rw_256x32_ctrl_chk #(
    parameter int                 CW        = 2,
    parameter logic [CW-1:0]      DEPTH_CNT = 2'd2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic [CW-1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == DEPTH_CNT)));

endmodule

// File: tb/tb_sram_1rw_256x32_ctrl.sv
// Directed bench for sram_1rw_256x32_ctrl with a behavioural 256x32 macro and a
// scoreboard that predicts read data from its own copy of memory.

module tb_sram_1rw_256x32_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [7:0]  sram_a;
    logic        sram_csb;
    logic        sram_web;
    logic        sram_oeb;
    logic [31:0] sram_i;
    logic [31:0] sram_o;

    always #5 clk = ~clk;

    sram_1rw_256x32_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_a    (sram_a),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_oeb  (sram_oeb),
        .sram_i    (sram_i),
        .sram_o    (sram_o)
    );

    // Macro model: synchronous write, read data registered and shown while OEB is low.
    logic [31:0] macro_mem [256];
    logic [31:0] macro_dout;
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) macro_mem[sram_a] <= sram_i;
            else           macro_dout        <= macro_mem[sram_a];
        end
    end
    assign sram_o = sram_oeb ? 32'h0000_0000 : macro_dout;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic        f;
    int          idx;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // One clock: drive at posedge+1, sample at negedge, score, advance.
    task automatic step(input logic v, input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic rr, output logic fired);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
        @(negedge clk);
        fired = req_valid & req_ready;
        if (rsp_valid && rsp_ready) begin
            got_q.push_back(rsp_rdata);
            if (exp_q.size() == 0) check("rsp_when_none_expected", {31'd0, rsp_valid}, 32'd0);
            else                   check("rsp_data", rsp_rdata, exp_q.pop_front());
        end
        if (fired) begin
            if (we) ref_mem[a] = d;
            else    exp_q.push_back(ref_mem[a]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        logic fd;
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, fd);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
        req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_csb",       {31'd0, sram_csb},  32'd1);
        check("rst_oeb",       {31'd0, sram_oeb},  32'd1);
        check("rst_rdata",     rsp_rdata,          32'h0);
        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic write then read with latency and OEB window checks
        step(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b1, f);
        check("t1_wr_fire", {31'd0, f}, 32'd1);
        step(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, f);
        check("t1_rd_fire", {31'd0, f}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("t1_oeb_n1",   {31'd0, sram_oeb},  32'd0);
        check("t1_valid_n1", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_valid_n2", {31'd0, rsp_valid}, 32'd1);
        check("t1_rdata_n2", rsp_rdata,          32'hDEADBEEF);
        check("t1_oeb_n2",   {31'd0, sram_oeb},  32'd1);
        @(posedge clk); #1;
        step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, f);
        check("t1_valid_after_pop", {31'd0, rsp_valid}, 32'd0);

        // Fill every address, then stream reads back
        for (int a = 0; a < 256; a++) step(1'b1, 1'b1, 8'(a), 32'(a) * 32'h01010101, 1'b1, f);
        got_q.delete();
        idx = 0;
        for (int c = 0; c < 2000 && idx < 256; c++) begin
            step(1'b1, 1'b0, 8'(idx), 32'h0, 1'b1, f);
            if (f) idx++;
        end
        check("t2_reads_accepted", 32'(idx), 32'd256);
        drain(50);
        check("t2_rsp_count", 32'(got_q.size()), 32'd256);
        check("t2_rsp_last",  got_q[255],        32'hFFFFFFFF);

        // Response backpressure: only two reads fit, writes still flow
        got_q.delete();
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 8'(idx + 1), 32'h0, 1'b0, f);
            if (f) idx++;
        end
        check("t3_bp_accepted", 32'(idx), 32'd2);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h03;
        @(negedge clk);
        check("t3_bp_rd_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        step(1'b1, 1'b1, 8'h80, 32'h80808080, 1'b0, f);
        check("t3_bp_wr_fire", {31'd0, f}, 32'd1);
        for (int c = 0; c < 50 && idx < 4; c++) begin
            step(1'b1, 1'b0, 8'(idx + 1), 32'h0, 1'b1, f);
            if (f) idx++;
        end
        check("t3_all_accepted", 32'(idx), 32'd4);
        drain(50);
        check("t3_rsp0", got_q[0], 32'h01010101);
        check("t3_rsp1", got_q[1], 32'h02020202);
        check("t3_rsp2", got_q[2], 32'h03030303);
        check("t3_rsp3", got_q[3], 32'h04040404);

        // Read/write hazards on the same address
        step(1'b1, 1'b1, 8'h20, 32'h1111, 1'b1, f);
        drain(10);
        got_q.delete();
        step(1'b1, 1'b0, 8'h20, 32'h0, 1'b1, f);
        check("t4_rd0_fire", {31'd0, f}, 32'd1);
        step(1'b1, 1'b1, 8'h20, 32'h2222, 1'b1, f);
        check("t4_wr_fire", {31'd0, f}, 32'd1);
        step(1'b1, 1'b0, 8'h20, 32'h0, 1'b1, f);
        check("t4_rd1_fire", {31'd0, f}, 32'd1);
        drain(20);
        check("t4_old_data", got_q[0], 32'h00001111);
        check("t4_new_data", got_q[1], 32'h00002222);

        // Reset with one response buffered and one read in flight
        got_q.delete();
        step(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, f);
        step(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, f);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_rst_csb",   {31'd0, sram_csb},  32'd1);
        check("t5_rst_oeb",   {31'd0, sram_oeb},  32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, f);
        check("t5_no_stale", 32'(got_q.size()), 32'd0);
        step(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, f);
        step(1'b1, 1'b0, 8'h20, 32'h0, 1'b1, f);
        drain(20);
        check("t5_mem_0x10", got_q[0], 32'h10101010);
        check("t5_mem_0x20", got_q[1], 32'h00002222);

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                 $urandom, 1'($urandom_range(0, 3) != 0), f);
        end
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
